rs_encoder_line_mux_in_ctrl: RTL and testbench
==============================================

Name: rs_encoder_line_mux_in_ctrl

Overview:
- Input-side sequencer for the line-muxed Reed-Solomon encoder array.
- Accepts wide data lines from the source, then steps the input datapath to serialize each line one byte at a time into the currently selected RS unit. A unit is filled with K_LINES lines, then the block moves to the next unit.
- Once all NUM_RS_UNITS units are loaded, it holds off new input and runs the done handshake with the output controller, one handshake per unit as the output controller drains that unit.

Parameters:
- NUM_RS_UNITS, 4, number of RS encoder units; must be >=2.
- NUM_RS_UNITS_W, $clog2(NUM_RS_UNITS), width of the unit select.
- LINE_BYTES, 32, bytes per input line; must be >=2.
- LINE_BYTES_W, $clog2(LINE_BYTES), width of the byte-in-line counter.
- K_LINES, 7, input lines per RS unit data block; must be >=1.
- K_LINES_W, $clog2(K_LINES+1), width of the line counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- src_encoder_line_val  in  1  source line valid.
- encoder_src_line_rdy  out  1  ready to accept a source line.
- in_ctrl_in_datap_store_line  out  1  datapath latches the source line into its shift register.
- in_ctrl_in_datap_shift_byte  out  1  datapath advances to the next byte of the latched line.
- in_ctrl_unit_sel  out  NUM_RS_UNITS_W  RS unit receiving bytes.
- in_ctrl_encoder_byte_val  out  1  byte valid to the selected unit.
- encoder_in_ctrl_byte_rdy  in  1  selected unit accepts a byte.
- in_ctrl_out_ctrl_done  out  1  all units loaded; waiting for drain.
- out_ctrl_in_ctrl_done  in  1  output controller finished draining the current unit.

Behaviour:
- Reset (rst_n low, asynchronous): state=READY; unit_sel, byte_cnt, line_cnt and drain_cnt all 0.
- Reset values of the registered and decoded outputs: encoder_src_line_rdy=1 (READY decode); all other outputs 0.
- Reset asserted mid-operation aborts the current block immediately. No partial state is retained.
- All outputs are combinational decodes of the state plus inputs. Counters update on the rising edge of clk.
- READY: line_rdy=1; byte_cnt, line_cnt, unit_sel and drain_cnt are forced to 0.
  - On line_val: store_line=1; go to FEED.
- FEED: byte_val=1.
  - Stall (byte_rdy=0): hold state and all counters.
  - On byte_rdy: shift_byte=1.
  - If byte_cnt != LINE_BYTES-1: byte_cnt++ and stay in FEED.
  - Else byte_cnt<=0, then:
    - If line_cnt != K_LINES-1: line_cnt++; go to LINE_WAIT.
    - Else if unit_sel != NUM_RS_UNITS-1: line_cnt<=0, unit_sel++; go to LINE_WAIT.
    - Else: go to WAIT_OUT.
- LINE_WAIT: line_rdy=1.
  - On line_val: store_line=1; go to FEED.
- Line-to-line throughput: one idle cycle minimum between the last byte of a line and the first byte of the next line.
- WAIT_OUT: in_ctrl_out_ctrl_done=1; line_rdy=0; unit_sel is held at NUM_RS_UNITS-1.
  - Handshake = out_ctrl_in_ctrl_done && in_ctrl_out_ctrl_done.
  - Each handshake increments drain_cnt.
  - Handshake with drain_cnt==NUM_RS_UNITS-1: go to READY, where unit_sel is cleared.
- out_ctrl_in_ctrl_done outside WAIT_OUT is ignored.
- Line latency: first byte_val on the cycle after the line handshake.
- Per-unit byte count: exactly K_LINES*LINE_BYTES byte handshakes per unit, in unit order 0..NUM_RS_UNITS-1.
- Counter rules: unsigned compares, no wrap-around. Each counter is explicitly cleared at its terminal value.
- Illegal state encodings: drive X on all outputs and next state (simulation only).

Test Plan:
- Fill sequence (NUM_RS_UNITS=2, LINE_BYTES=4, K_LINES=2, line_val always 1, byte_rdy always 1):
  - Response: 4 lines accepted; unit_sel=0 for bytes 0-7 and 1 for bytes 8-15.
  - Response: in_ctrl_out_ctrl_done rises the cycle after the 16th byte.
- Drain handshake (same config, after the fill): pulse out_ctrl_in_ctrl_done twice, 3 cycles apart.
  - Response: stays in WAIT_OUT after the first pulse; line_rdy=1 and unit_sel=0 the cycle after the second pulse.
- Backpressure: byte_rdy toggles 1,0,0,1,...
  - Response: shift_byte only on rdy cycles; exactly 16 shifts per full block; no byte skipped or duplicated.
- Source starvation: line_val withheld 5 cycles in LINE_WAIT.
  - Response: byte_val stays 0; line_cnt and unit_sel unchanged; feeding resumes the cycle after line_val.
- Reset mid-FEED (unit_sel=1, byte_cnt=2): drop rst_n asynchronously.
  - Response: outputs go to reset values immediately; the next block starts at unit 0, byte 0.
- Early done: out_ctrl_in_ctrl_done=1 during FEED.
  - Response: ignored; drain_cnt stays 0; WAIT_OUT still requires 2 handshakes.

Source files
------------

// File: rtl/rs_encoder_line_mux_in_ctrl.sv
// Input-side sequencer for the line-muxed RS encoder array: serializes source lines
// byte by byte into each RS unit in turn, then handshakes the drain with the output side.
module rs_encoder_line_mux_in_ctrl #(
  parameter int unsigned NUM_RS_UNITS   = 4,
  parameter int unsigned NUM_RS_UNITS_W = $clog2(NUM_RS_UNITS),
  parameter int unsigned LINE_BYTES     = 32,
  parameter int unsigned LINE_BYTES_W   = $clog2(LINE_BYTES),
  parameter int unsigned K_LINES        = 7,
  parameter int unsigned K_LINES_W      = $clog2(K_LINES + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      src_encoder_line_val,
  output logic                      encoder_src_line_rdy,
  output logic                      in_ctrl_in_datap_store_line,
  output logic                      in_ctrl_in_datap_shift_byte,
  output logic [NUM_RS_UNITS_W-1:0] in_ctrl_unit_sel,
  output logic                      in_ctrl_encoder_byte_val,
  input  logic                      encoder_in_ctrl_byte_rdy,
  output logic                      in_ctrl_out_ctrl_done,
  input  logic                      out_ctrl_in_ctrl_done
);

  localparam logic [LINE_BYTES_W-1:0]   BYTE_LAST = LINE_BYTES_W'(LINE_BYTES - 1);
  localparam logic [K_LINES_W-1:0]      LINE_LAST = K_LINES_W'(K_LINES - 1);
  localparam logic [NUM_RS_UNITS_W-1:0] UNIT_LAST = NUM_RS_UNITS_W'(NUM_RS_UNITS - 1);

  typedef enum logic [1:0] {
    READY     = 2'd0,
    FEED      = 2'd1,
    LINE_WAIT = 2'd2,
    WAIT_OUT  = 2'd3
  } state_t;

  state_t                    state, state_nxt;
  logic [LINE_BYTES_W-1:0]   byte_cnt, byte_cnt_nxt;
  logic [K_LINES_W-1:0]      line_cnt, line_cnt_nxt;
  logic [NUM_RS_UNITS_W-1:0] unit_sel, unit_sel_nxt;
  logic [NUM_RS_UNITS_W-1:0] drain_cnt, drain_cnt_nxt;

  assign in_ctrl_unit_sel = unit_sel;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= READY;
      byte_cnt  <= '0;
      line_cnt  <= '0;
      unit_sel  <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      byte_cnt  <= byte_cnt_nxt;
      line_cnt  <= line_cnt_nxt;
      unit_sel  <= unit_sel_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Next-state, counter update and output decode
  always_comb begin
    state_nxt                   = state;
    byte_cnt_nxt                = byte_cnt;
    line_cnt_nxt                = line_cnt;
    unit_sel_nxt                = unit_sel;
    drain_cnt_nxt               = drain_cnt;
    encoder_src_line_rdy        = 1'b0;
    in_ctrl_in_datap_store_line = 1'b0;
    in_ctrl_in_datap_shift_byte = 1'b0;
    in_ctrl_encoder_byte_val    = 1'b0;
    in_ctrl_out_ctrl_done       = 1'b0;

    case (state)
      READY: begin
        encoder_src_line_rdy = 1'b1;
        byte_cnt_nxt         = '0;
        line_cnt_nxt         = '0;
        unit_sel_nxt         = '0;
        drain_cnt_nxt        = '0;
        if (src_encoder_line_val) begin
          in_ctrl_in_datap_store_line = 1'b1;
          state_nxt                   = FEED;
        end
      end

      FEED: begin
        in_ctrl_encoder_byte_val = 1'b1;
        if (encoder_in_ctrl_byte_rdy) begin
          in_ctrl_in_datap_shift_byte = 1'b1;
          if (byte_cnt != BYTE_LAST) begin
            byte_cnt_nxt = byte_cnt + LINE_BYTES_W'(1);
          end else begin
            byte_cnt_nxt = '0;
            if (line_cnt != LINE_LAST) begin
              line_cnt_nxt = line_cnt + K_LINES_W'(1);
              state_nxt    = LINE_WAIT;
            end else if (unit_sel != UNIT_LAST) begin
              line_cnt_nxt = '0;
              unit_sel_nxt = unit_sel + NUM_RS_UNITS_W'(1);
              state_nxt    = LINE_WAIT;
            end else begin
              state_nxt = WAIT_OUT;
            end
          end
        end
      end

      LINE_WAIT: begin
        encoder_src_line_rdy = 1'b1;
        if (src_encoder_line_val) begin
          in_ctrl_in_datap_store_line = 1'b1;
          state_nxt                   = FEED;
        end
      end

      WAIT_OUT: begin
        // One drain handshake per unit; the last one releases the array for a new block
        in_ctrl_out_ctrl_done = 1'b1;
        if (out_ctrl_in_ctrl_done) begin
          if (drain_cnt == UNIT_LAST) begin
            drain_cnt_nxt = '0;
            unit_sel_nxt  = '0;
            state_nxt     = READY;
          end else begin
            drain_cnt_nxt = drain_cnt + NUM_RS_UNITS_W'(1);
          end
        end
      end

      default: begin
        state_nxt                   = state_t'('x);
        byte_cnt_nxt                = 'x;
        line_cnt_nxt                = 'x;
        unit_sel_nxt                = 'x;
        drain_cnt_nxt               = 'x;
        encoder_src_line_rdy        = 1'bx;
        in_ctrl_in_datap_store_line = 1'bx;
        in_ctrl_in_datap_shift_byte = 1'bx;
        in_ctrl_encoder_byte_val    = 1'bx;
        in_ctrl_out_ctrl_done       = 1'bx;
      end
    endcase
  end

endmodule

// File: tb/tb_rs_encoder_line_mux_in_ctrl.sv
// Bench for rs_encoder_line_mux_in_ctrl: a negedge monitor scores every byte handshake
// against the unit expected from the count of accepted lines.
module tb_rs_encoder_line_mux_in_ctrl;

  localparam int unsigned NU  = 2;
  localparam int unsigned LB  = 4;
  localparam int unsigned KL  = 2;
  localparam int unsigned NUW = $clog2(NU);
  localparam int unsigned BLOCK_BYTES = NU * LB * KL;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           line_val;
  logic           line_rdy;
  logic           store_line;
  logic           shift_byte;
  logic [NUW-1:0] unit_sel;
  logic           byte_val;
  logic           byte_rdy;
  logic           done;
  logic           out_done;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int lines_m   = 0;
  int n_byte_hs = 0;
  int n_shift   = 0;

  always #5 clk = ~clk;

  rs_encoder_line_mux_in_ctrl #(
    .NUM_RS_UNITS(NU),
    .LINE_BYTES  (LB),
    .K_LINES     (KL)
  ) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .src_encoder_line_val       (line_val),
    .encoder_src_line_rdy       (line_rdy),
    .in_ctrl_in_datap_store_line(store_line),
    .in_ctrl_in_datap_shift_byte(shift_byte),
    .in_ctrl_unit_sel           (unit_sel),
    .in_ctrl_encoder_byte_val   (byte_val),
    .encoder_in_ctrl_byte_rdy   (byte_rdy),
    .in_ctrl_out_ctrl_done      (done),
    .out_ctrl_in_ctrl_done      (out_done)
  );

  // Scoreboard: push per-byte unit on line accept, pop on byte handshake
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (store_line !== (line_val && line_rdy)) begin
        errors++;
        $display("FAIL store_line: got %b expected %b", store_line, line_val && line_rdy);
      end
      if (line_val && line_rdy) begin
        for (int i = 0; i < LB; i++) exp_q.push_back(lines_m / KL);
        lines_m++;
      end
      checks++;
      if (shift_byte !== (byte_val && byte_rdy)) begin
        errors++;
        $display("FAIL shift_byte: got %b expected %b", shift_byte, byte_val && byte_rdy);
      end
      if (shift_byte === 1'b1) n_shift++;
      if (byte_val && byte_rdy) begin
        n_byte_hs++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL byte_unit: got byte on unit %0d expected no byte", unit_sel);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (32'(unit_sel) !== 32'(e)) begin
            errors++;
            $display("FAIL byte_unit: got %0d expected %0d", unit_sel, e);
          end
        end
      end
    end
  end

  task automatic clear_model();
    exp_q.delete();
    lines_m   = 0;
    n_byte_hs = 0;
    n_shift   = 0;
  endtask

  task automatic run_until_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      @(negedge clk); #1;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; line_val = 1'b0; byte_rdy = 1'b0; out_done = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({line_rdy, store_line, shift_byte, byte_val, done} !== 5'b10000 || unit_sel !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b st=%b sh=%b bv=%b dn=%b us=%0d expected 1 0 0 0 0 0",
               line_rdy, store_line, shift_byte, byte_val, done, unit_sel);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    int  prev_hs;
    bit  got;
    clear_model();
    prev_hs = 0;
    got     = 1'b0;
    @(posedge clk); #1;
    line_val = 1'b1; byte_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      checks++;
      if (prev_hs == BLOCK_BYTES) begin
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL fill_done_rise: got %b expected 1", done);
        end
        got = 1'b1;
        break;
      end else if (done !== 1'b0) begin
        errors++;
        $display("FAIL fill_done_early: got %b expected 0 after %0d bytes", done, prev_hs);
      end
      prev_hs = n_byte_hs;
      @(posedge clk); #1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL fill_timeout: got %0d bytes expected %0d", n_byte_hs, BLOCK_BYTES);
    end
    checks++;
    if (lines_m != NU * KL || n_shift != BLOCK_BYTES || line_rdy !== 1'b0) begin
      errors++;
      $display("FAIL fill_totals: got lines=%0d shifts=%0d rdy=%b expected %0d %0d 0",
               lines_m, n_shift, line_rdy, NU * KL, BLOCK_BYTES);
    end
  endtask

  task automatic test_drain();
    @(posedge clk); #1;
    line_val = 1'b0; out_done = 1'b1;
    @(posedge clk); #1;
    out_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      checks++;
      if (done !== 1'b1 || line_rdy !== 1'b0) begin
        errors++;
        $display("FAIL drain_hold: got done=%b rdy=%b expected 1 0", done, line_rdy);
      end
      @(posedge clk); #1;
    end
    out_done = 1'b1;
    @(posedge clk); #1;
    out_done = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (line_rdy !== 1'b1 || unit_sel !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL drain_release: got rdy=%b us=%0d done=%b expected 1 0 0", line_rdy, unit_sel, done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_leftover: got %0d pending bytes expected 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit got;
    int k;
    clear_model();
    got = 1'b0;
    k   = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      line_val = 1'b1;
      byte_rdy = (k % 3 == 0);
      k++;
      @(negedge clk); #1;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    byte_rdy = 1'b1;
    checks++;
    if (!got || n_shift != BLOCK_BYTES || n_byte_hs != BLOCK_BYTES || lines_m != NU * KL) begin
      errors++;
      $display("FAIL bp_totals: got done=%b shifts=%0d bytes=%0d lines=%0d expected 1 %0d %0d %0d",
               got, n_shift, n_byte_hs, lines_m, BLOCK_BYTES, BLOCK_BYTES, NU * KL);
    end
    test_drain();
  endtask

  task automatic test_starvation();
    bit got;
    clear_model();
    got = 1'b0;
    @(posedge clk); #1;
    line_val = 1'b1; byte_rdy = 1'b1;
    @(posedge clk); #1;
    line_val = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (line_rdy === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL starve_line_wait: got rdy=%b expected 1", line_rdy);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk); #1;
      checks++;
      if (byte_val !== 1'b0 || unit_sel !== '0 || line_rdy !== 1'b1) begin
        errors++;
        $display("FAIL starve_idle: got bv=%b us=%0d rdy=%b expected 0 0 1", byte_val, unit_sel, line_rdy);
      end
    end
    @(posedge clk); #1;
    line_val = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (byte_val !== 1'b1 || unit_sel !== '0) begin
      errors++;
      $display("FAIL starve_resume: got bv=%b us=%0d expected 1 0", byte_val, unit_sel);
    end
    run_until_done(200, got);
    checks++;
    if (!got || n_byte_hs != BLOCK_BYTES) begin
      errors++;
      $display("FAIL starve_totals: got done=%b bytes=%0d expected 1 %0d", got, n_byte_hs, BLOCK_BYTES);
    end
    test_drain();
  endtask

  task automatic test_reset_mid_feed();
    bit got;
    clear_model();
    got = 1'b0;
    @(posedge clk); #1;
    line_val = 1'b1; byte_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (n_byte_hs == LB * KL + 3) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (!got || unit_sel !== NUW'(1) || byte_val !== 1'b1) begin
      errors++;
      $display("FAIL midreset_setup: got reached=%b us=%0d bv=%b expected 1 1 1", got, unit_sel, byte_val);
    end
    line_val = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++;
    if ({line_rdy, store_line, shift_byte, byte_val, done} !== 5'b10000 || unit_sel !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got rdy=%b st=%b sh=%b bv=%b dn=%b us=%0d expected 1 0 0 0 0 0",
               line_rdy, store_line, shift_byte, byte_val, done, unit_sel);
    end
    clear_model();
    @(posedge clk); #1;
    rst_n    = 1'b1;
    line_val = 1'b1;
    run_until_done(200, got);
    checks++;
    if (!got || n_byte_hs != BLOCK_BYTES || lines_m != NU * KL) begin
      errors++;
      $display("FAIL midreset_block: got done=%b bytes=%0d lines=%0d expected 1 %0d %0d",
               got, n_byte_hs, lines_m, BLOCK_BYTES, NU * KL);
    end
    test_drain();
  endtask

  task automatic test_early_done();
    bit got;
    clear_model();
    got = 1'b0;
    @(posedge clk); #1;
    line_val = 1'b1; byte_rdy = 1'b1; out_done = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) out_done = 1'b0;
      @(negedge clk); #1;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    out_done = 1'b0;
    checks++;
    if (!got || n_byte_hs != BLOCK_BYTES) begin
      errors++;
      $display("FAIL early_done_fill: got done=%b bytes=%0d expected 1 %0d", got, n_byte_hs, BLOCK_BYTES);
    end
    test_drain();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_backpressure();
    test_starvation();
    test_reset_mid_feed();
    test_early_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
